twd_stage_seq: RTL and testbench

Frame sequencer for a twiddle-multiply stage of the FFT pipeline. It accepts input beats under a valid/ready handshake and counts beats within a frame of CLK_CNT cycles. It drives the twiddle datapath's enable, beat count and twiddle-group index, and tracks the datapath latency so it can flag when a frame's results leave the stage. Between frames it inserts a drain gap so frame boundaries never overlap inside the multiplier.

---
 rtl/twd_stage_seq.sv | 128 ++++++++++++
 tb/tb_twd_stage_seq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twd_stage_seq.sv
// Frame sequencer for a twiddle-multiply FFT stage.
// Accepts beats under valid/ready and counts them within a frame of CLK_CNT beats.
// It drives the twiddle datapath enable, the beat count and the twiddle-group index.
// It tracks the datapath latency so that it can flag results leaving the stage.
// A PIPE_LAT-cycle drain gap keeps frames from overlapping inside the multiplier.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   upstream beat handshake (in_ready decoded from state only)
//   flush               synchronous abort of the current frame
//   twd_valid           beat accepted this cycle (datapath enable)
//   twd_cnt, twd_idx    beat index within frame; twiddle group = twd_cnt / GRP_LEN
//   frame_start/last    accepted beat is first / last of frame
//   out_valid/out_last  twd_valid / frame_last delayed by PIPE_LAT
//   busy                not idle
//   frame_cnt           completed frames, wraps at 256
module twd_stage_seq #(
  parameter int unsigned CLK_CNT  = 16,
  parameter int unsigned GRP_LEN  = 4,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic       twd_valid,
  output logic [3:0] twd_cnt,
  output logic [3:0] twd_idx,
  output logic       frame_start,
  output logic       frame_last,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int unsigned GrpShift  = $clog2(GRP_LEN);
  localparam logic [3:0]  LastCnt   = 4'(CLK_CNT - 1);
  localparam logic [2:0]  DrainLast = 3'(PIPE_LAT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          drain_q, drain_d;
  logic [PIPE_LAT-1:0] vld_sr_q, last_sr_q;
  logic [PIPE_LAT:0]   vld_shift, last_shift;
  logic [7:0]          frame_q;

  assign in_ready    = ((state_q == StIdle) || (state_q == StRun)) && !rst;
  assign twd_valid   = in_valid && in_ready;
  assign frame_start = twd_valid && (cnt_q == 4'd0);
  assign frame_last  = twd_valid && (cnt_q == LastCnt);
  assign twd_cnt     = cnt_q;
  assign twd_idx     = cnt_q >> GrpShift;
  assign out_valid   = vld_sr_q[PIPE_LAT-1];
  assign out_last    = last_sr_q[PIPE_LAT-1];
  assign busy        = (state_q != StIdle);
  assign frame_cnt   = frame_q;

  // A beat taken in a flush cycle is still signalled but must not reach the delay lines.
  // The extra low bit lets one slice expression work for every PIPE_LAT, including 1.
  assign vld_shift  = {vld_sr_q, twd_valid && !flush};
  assign last_shift = {last_sr_q, frame_last && !flush};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = 4'd0;
      drain_d = 3'd0;
    end else begin
      case (state_q)
        StIdle, StRun: begin
          if (twd_valid) begin
            if (cnt_q == LastCnt) begin
              cnt_d   = 4'd0;
              drain_d = 3'd0;
              state_d = StDrain;
            end else begin
              cnt_d   = cnt_q + 4'd1;
              state_d = StRun;
            end
          end
        end
        StDrain: begin
          // drain_q reaches DrainLast in the cycle the last result shows out_last.
          if (drain_q == DrainLast) begin
            drain_d = 3'd0;
            state_d = StIdle;
          end else begin
            drain_d = drain_q + 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      drain_q   <= 3'd0;
      vld_sr_q  <= '0;
      last_sr_q <= '0;
      frame_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      if (flush) begin
        vld_sr_q  <= '0;
        last_sr_q <= '0;
      end else begin
        vld_sr_q  <= vld_shift[PIPE_LAT-1:0];
        last_sr_q <= last_shift[PIPE_LAT-1:0];
        if (out_last) frame_q <= frame_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_twd_stage_seq.sv
module tb_twd_stage_seq;
  localparam int CC  = 16;
  localparam int GL  = 4;
  localparam int PL  = 2;
  localparam int CC2 = 8;
  localparam int GL2 = 2;
  localparam int PL2 = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, flush;
  logic       in_ready, twd_valid, frame_start, frame_last, out_valid, out_last, busy;
  logic [3:0] twd_cnt, twd_idx;
  logic [7:0] frame_cnt;

  logic       rst_b, in_valid_b, flush_b;
  logic       in_ready_b, twd_valid_b, frame_start_b, frame_last_b;
  logic       out_valid_b, out_last_b, busy_b;
  logic [3:0] twd_cnt_b, twd_idx_b;
  logic [7:0] frame_cnt_b;
  bit         done_b = 1'b0;

  always #5 clk = ~clk;

  twd_stage_seq #(.CLK_CNT(CC), .GRP_LEN(GL), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .twd_valid(twd_valid), .twd_cnt(twd_cnt), .twd_idx(twd_idx),
    .frame_start(frame_start), .frame_last(frame_last), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
  );

  twd_stage_seq #(.CLK_CNT(CC2), .GRP_LEN(GL2), .PIPE_LAT(PL2)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
    .twd_valid(twd_valid_b), .twd_cnt(twd_cnt_b), .twd_idx(twd_idx_b),
    .frame_start(frame_start_b), .frame_last(frame_last_b), .out_valid(out_valid_b),
    .out_last(out_last_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  // Expected result: the cycle it must appear in and whether it closes a frame.
  typedef struct {
    int cyc;
    bit last;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         m_cnt = 0;   // beat index the next accepted beat will carry
  int         m_gap = 0;   // remaining not-ready cycles after a frame
  logic [7:0] exp_frames = 8'd0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1: drive, check combinational outputs, advance the model at the edge.
  task automatic step(input bit v, input bit f);
    int c;
    bit rdy, acc;
    in_valid = v;
    flush    = f;
    #1;
    c   = cyc;
    rdy = (m_gap == 0);
    acc = v && rdy;
    chk("in_ready", int'(in_ready), int'(rdy));
    chk("twd_valid", int'(twd_valid), int'(acc));
    chk("twd_cnt", int'(twd_cnt), m_cnt);
    chk("twd_idx", int'(twd_idx), m_cnt / GL);
    chk("frame_start", int'(frame_start), int'(acc && m_cnt == 0));
    chk("frame_last", int'(frame_last), int'(acc && m_cnt == CC - 1));
    chk("busy", int'(busy), int'(m_cnt != 0 || m_gap != 0));
    @(posedge clk);
    if (f) begin
      m_cnt = 0;
      m_gap = 0;
      while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
    end else if (acc) begin
      exp_q.push_back('{cyc: c + PL, last: (m_cnt == CC - 1)});
      if (m_cnt == CC - 1) begin
        m_cnt = 0;
        m_gap = PL;
      end else begin
        m_cnt++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end
    #1;
  endtask

  // Monitor: pops the scoreboard whenever a result is due and checks frame_cnt.
  initial forever begin
    bit   exp_v;
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("frame_cnt", int'(frame_cnt), int'(exp_frames));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_missing: got none, expected result due at cycle %0d", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("out_valid", int'(out_valid), int'(exp_v));
      if (exp_v) begin
        e = exp_q.pop_front();
        chk("out_last", int'(out_last), int'(e.last));
        if (e.last && !flush) exp_frames = exp_frames + 8'd1;
      end else begin
        chk("out_last_idle", int'(out_last), 0);
      end
    end
  end

  // Alternate configuration: back-to-back frames, twd_idx and drain-gap length.
  initial begin
    int k, g, nlast;
    rst_b      = 1'b1;
    in_valid_b = 1'b0;
    flush_b    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_b      = 1'b0;
    in_valid_b = 1'b1;
    k     = 0;
    g     = 0;
    nlast = 0;
    for (int i = 0; i < 3 * (CC2 + PL2); i++) begin
      #1;
      chk("b_in_ready", int'(in_ready_b), int'(g == 0));
      if (g == 0) begin
        chk("b_twd_cnt", int'(twd_cnt_b), k);
        chk("b_twd_idx", int'(twd_idx_b), k / GL2);
      end
      @(posedge clk);
      if (g == 0) begin
        if (k == CC2 - 1) begin
          k = 0;
          g = PL2;
          nlast++;
        end else begin
          k++;
        end
      end else begin
        g--;
      end
      #1;
    end
    in_valid_b = 1'b0;
    repeat (PL2 + 2) @(posedge clk);
    #1;
    chk("b_frame_cnt", int'(frame_cnt_b), nlast);
    done_b = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    flush    = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_twd_valid", int'(twd_valid), 0);
    chk("rst_twd_cnt", int'(twd_cnt), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Back-to-back frame
    repeat (CC) step(1'b1, 1'b0);
    repeat (PL + 2) step(1'b0, 1'b0);
    chk("b2b_frame_cnt", int'(frame_cnt), 1);

    // Stalls after beats 5 and 11
    for (int b = 0; b < CC; b++) begin
      step(1'b1, 1'b0);
      if (b == 5 || b == 11) repeat (3) step(1'b0, 1'b0);
    end
    repeat (PL + 2) step(1'b0, 1'b0);
    chk("stall_frame_cnt", int'(frame_cnt), 2);

    // Flush at beat 9, then next beat restarts the frame
    for (int i = 0; i < 40 && m_cnt != 9; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (CC - 1) step(1'b1, 1'b0);
    repeat (PL + 2) step(1'b0, 1'b0);
    chk("flush9_frame_cnt", int'(frame_cnt), 3);

    // Flush coincident with the last beat
    for (int i = 0; i < 40 && !(m_cnt == CC - 1 && m_gap == 0); i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (PL + 2) step(1'b0, 1'b0);
    chk("flush15_frame_cnt", int'(frame_cnt), 3);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 3000; i++) step($urandom_range(3) != 0, $urandom_range(59) == 0);

    // Asynchronous reset in the drain gap
    for (int i = 0; i < 60 && !(m_cnt == CC - 1 && m_gap == 0); i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_twd_valid", int'(twd_valid), 0);
    chk("arst_frame_start", int'(frame_start), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_last", int'(out_last), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_frame_cnt", int'(frame_cnt), 0);
    exp_q.delete();
    m_cnt      = 0;
    m_gap      = 0;
    exp_frames = 8'd0;
    in_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 256 back-to-back frames wrap frame_cnt to 0
    repeat (256 * (CC + PL)) step(1'b1, 1'b0);
    repeat (PL + 2) step(1'b0, 1'b0);
    chk("wrap_frame_cnt", int'(frame_cnt), 0);

    for (int i = 0; i < 2000 && !done_b; i++) @(posedge clk);
    chk("alt_config_done", int'(done_b), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
